// File: rtl/synth_audio_pkg.sv
// Shared audio definitions for the synth output path: default widths and the
// stereo sample pair handed from the mixer to the output stages.
package synth_audio_pkg;

   localparam int unsigned DefDataW    = 16;  // mixer sample width
   localparam int unsigned DefSlotBits = 32;  // BCLK periods per I2S channel slot
   localparam int unsigned DefBclkDiv  = 4;   // system clocks per BCLK half-period

   // One mixed stereo sample; l occupies the upper half when packed.
   typedef struct packed {
      logic signed [DefDataW-1:0] l;
      logic signed [DefDataW-1:0] r;
   } stereo_sample_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S timing generator: divides the system clock down to BCLK, flags the
// BCLK falling edge, and tracks the bit position within the stereo frame.
// bit_cnt_o is the position the frame moves to on the current fall event,
// so the parent can pick the serial bit in the same cycle.
module i2s_bclk_gen
   import synth_audio_pkg::*;
#(
   parameter int unsigned BCLK_DIV  = DefBclkDiv,
   parameter int unsigned SLOT_BITS = DefSlotBits,
   localparam int unsigned BitW     = $clog2(2 * SLOT_BITS)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            bclk_o,
   output logic            lrck_o,
   output logic            fall_o,
   output logic            frame_load_o,
   output logic [BitW-1:0] bit_cnt_o
);

   localparam int unsigned DivW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam logic [DivW-1:0] DivMax   = DivW'(BCLK_DIV - 1);
   localparam logic [BitW-1:0] BitMax   = BitW'(2 * SLOT_BITS - 1);
   localparam logic [BitW-1:0] SlotSize = BitW'(SLOT_BITS);

   logic [DivW-1:0] div_q, div_d;
   logic            bclk_q, bclk_d;
   logic [BitW-1:0] bit_q, bit_d;
   logic            lrck_q, lrck_d;
   logic            div_wrap;
   logic            fall;
   logic [BitW-1:0] bit_nxt;

   // Divider, BCLK toggle, and frame position advance on BCLK falling edges.
   always_comb begin
      div_wrap = (div_q == DivMax);
      fall     = div_wrap && bclk_q;
      div_d    = div_wrap ? '0 : div_q + DivW'(1);
      bclk_d   = div_wrap ? ~bclk_q : bclk_q;
      bit_nxt  = (bit_q == BitMax) ? '0 : bit_q + BitW'(1);
      bit_d    = bit_q;
      lrck_d   = lrck_q;
      if (fall) begin
         bit_d  = bit_nxt;
         lrck_d = (bit_nxt >= SlotSize);
      end
   end

   // Timing state; bit_q resets to the last position so the first fall is a frame load.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q  <= '0;
         bclk_q <= 1'b0;
         bit_q  <= BitMax;
         lrck_q <= 1'b0;
      end else begin
         div_q  <= div_d;
         bclk_q <= bclk_d;
         bit_q  <= bit_d;
         lrck_q <= lrck_d;
      end
   end

   assign bclk_o       = bclk_q;
   assign lrck_o       = lrck_q;
   assign fall_o       = fall;
   assign frame_load_o = fall && (bit_q == BitMax);
   assign bit_cnt_o    = bit_nxt;

endmodule

// File: rtl/i2s_out_serializer.sv
// Stereo I2S output stage. Holds one mixed sample pair in a single-entry
// buffer, latches it into the shift words at each frame start and sends it
// MSB-first in Philips I2S format (data one BCLK after the LRCK edge).
// Sticky flags expose rate mismatches between mixer and audio frame rate.
module i2s_out_serializer
   import synth_audio_pkg::*;
#(
   parameter int unsigned BCLK_DIV  = DefBclkDiv,
   parameter int unsigned SLOT_BITS = DefSlotBits,
   parameter int unsigned DATA_W    = DefDataW
) (
   input  logic                     sCLK_AUDIO,
   input  logic                     iRST,
   input  logic                     iSAMPLE_VALID,
   input  logic signed [DATA_W-1:0] iL_SAMPLE,
   input  logic signed [DATA_W-1:0] iR_SAMPLE,
   input  logic                     iMUTE,
   input  logic                     iCLR_FLAGS,
   output logic                     oSAMPLE_REQ,
   output logic                     oBCLK,
   output logic                     oLRCK,
   output logic                     oSDATA,
   output logic                     oOVERRUN,
   output logic                     oUNDERRUN
);

   localparam int unsigned BitW = $clog2(2 * SLOT_BITS);
   localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BitW-1:0] SlotSize = BitW'(SLOT_BITS);
   localparam logic [BitW-1:0] DataLen  = BitW'(DATA_W);

   typedef struct packed {
      logic signed [DATA_W-1:0] l;
      logic signed [DATA_W-1:0] r;
   } pair_t;

   logic            fall;
   logic            frame_load;
   logic [BitW-1:0] bit_nxt;

   pair_t buf_q, buf_d;        // holding buffer written by the mixer
   logic  full_q, full_d;
   pair_t last_q, last_d;      // last pair taken from the buffer, replayed on underrun
   pair_t word_q, word_d;      // words being shifted out this frame
   logic  sdata_q, sdata_d;
   logic  req_q, req_d;
   logic  ovr_q, ovr_d;
   logic  und_q, und_d;

   pair_t             frame_pair;
   logic [BitW-1:0]   slot_pos;
   logic [DATA_W-1:0] slot_word;
   logic [IdxW-1:0]   bit_idx;
   logic              serial_bit;

   i2s_bclk_gen #(
      .BCLK_DIV  (BCLK_DIV),
      .SLOT_BITS (SLOT_BITS)
   ) u_bclk_gen (
      .clk_i        (sCLK_AUDIO),
      .rst_i        (iRST),
      .bclk_o       (oBCLK),
      .lrck_o       (oLRCK),
      .fall_o       (fall),
      .frame_load_o (frame_load),
      .bit_cnt_o    (bit_nxt)
   );

   // Pick the serial bit for the slot position being entered; bit 0 of each
   // slot and everything past the sample width are padding zeros.
   always_comb begin
      slot_pos   = (bit_nxt >= SlotSize) ? bit_nxt - SlotSize : bit_nxt;
      slot_word  = (bit_nxt >= SlotSize) ? word_q.r : word_q.l;
      bit_idx    = IdxW'(DATA_W - 32'(slot_pos));
      serial_bit = 1'b0;
      if (slot_pos != '0 && slot_pos <= DataLen) begin
         serial_bit = slot_word[bit_idx];
      end
      sdata_d = fall ? serial_bit : sdata_q;
   end

   // Buffer handoff at frame load, mixer writes, and sticky flag updates.
   always_comb begin
      buf_d      = buf_q;
      full_d     = full_q;
      last_d     = last_q;
      word_d     = word_q;
      req_d      = 1'b0;
      ovr_d      = ovr_q;
      und_d      = und_q;
      frame_pair = full_q ? buf_q : last_q;

      if (frame_load) begin
         last_d = frame_pair;
         word_d = iMUTE ? '0 : frame_pair;
         full_d = 1'b0;
         req_d  = 1'b1;
      end

      // A write in the load cycle lands after the frame has taken the old pair.
      if (iSAMPLE_VALID) begin
         buf_d.l = iL_SAMPLE;
         buf_d.r = iR_SAMPLE;
         full_d  = 1'b1;
      end

      if (iCLR_FLAGS) begin
         ovr_d = 1'b0;
         und_d = 1'b0;
      end
      if (iSAMPLE_VALID && full_q && !frame_load) begin
         ovr_d = 1'b1;
      end
      if (frame_load && !full_q) begin
         und_d = 1'b1;
      end
   end

   // Datapath and flag registers.
   always_ff @(posedge sCLK_AUDIO or posedge iRST) begin
      if (iRST) begin
         buf_q   <= '0;
         full_q  <= 1'b0;
         last_q  <= '0;
         word_q  <= '0;
         sdata_q <= 1'b0;
         req_q   <= 1'b0;
         ovr_q   <= 1'b0;
         und_q   <= 1'b0;
      end else begin
         buf_q   <= buf_d;
         full_q  <= full_d;
         last_q  <= last_d;
         word_q  <= word_d;
         sdata_q <= sdata_d;
         req_q   <= req_d;
         ovr_q   <= ovr_d;
         und_q   <= und_d;
      end
   end

   assign oSDATA      = sdata_q;
   assign oSAMPLE_REQ = req_q;
   assign oOVERRUN    = ovr_q;
   assign oUNDERRUN   = und_q;

endmodule

// File: tb/tb_i2s_out_serializer.sv
// Bench for i2s_out_serializer: a time-based reference model checked every
// cycle, a table of frame vectors, hand-written corner sequences and a
// randomized stretch.
module tb_i2s_out_serializer;

   localparam int unsigned BclkDiv  = 4;
   localparam int unsigned SlotBits = 32;
   localparam int unsigned DataW    = 16;
   localparam int unsigned FrameClk = 2 * BclkDiv * 2 * SlotBits;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [15:0] l_in = '0;
   logic [15:0] r_in = '0;
   logic        mute = 1'b0;
   logic        clr = 1'b0;
   logic        req, bclk, lrck, sdata, ovr, und;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   i2s_out_serializer #(
      .BCLK_DIV  (BclkDiv),
      .SLOT_BITS (SlotBits),
      .DATA_W    (DataW)
   ) dut (
      .sCLK_AUDIO    (clk),
      .iRST          (rst),
      .iSAMPLE_VALID (valid),
      .iL_SAMPLE     (l_in),
      .iR_SAMPLE     (r_in),
      .iMUTE         (mute),
      .iCLR_FLAGS    (clr),
      .oSAMPLE_REQ   (req),
      .oBCLK         (bclk),
      .oLRCK         (lrck),
      .oSDATA        (sdata),
      .oOVERRUN      (ovr),
      .oUNDERRUN     (und)
   );

   // ---------------- reference model ----------------
   // t counts clocks since reset release; BCLK phase and frame position are
   // derived from t arithmetically, buffer/flags follow the behavioural rules.
   typedef struct packed {
      logic [31:0] t;
      logic [15:0] bl, br, ll, lr, wl, wr;
      logic        full, ovr, und, req;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t step(input mdl_t c, input logic v, input logic [15:0] l,
                                 input logic [15:0] r, input logic mu, input logic cl);
      mdl_t n;
      logic fall, load, so, su;
      int unsigned k;
      n     = c;
      n.t   = c.t + 1;
      n.req = 1'b0;
      k     = n.t / (2 * BclkDiv);
      fall  = (n.t % (2 * BclkDiv)) == 0;
      load  = fall && (((k - 1) % (2 * SlotBits)) == 0);
      so    = v && c.full && !load;
      su    = load && !c.full;
      if (load) begin
         n.ll   = c.full ? c.bl : c.ll;
         n.lr   = c.full ? c.br : c.lr;
         n.wl   = mu ? 16'h0 : n.ll;
         n.wr   = mu ? 16'h0 : n.lr;
         n.full = 1'b0;
         n.req  = 1'b1;
      end
      if (v) begin
         n.bl   = l;
         n.br   = r;
         n.full = 1'b1;
      end
      if (cl) begin
         n.ovr = 1'b0;
         n.und = 1'b0;
      end
      if (so) n.ovr = 1'b1;
      if (su) n.und = 1'b1;
      return n;
   endfunction

   // Expected {bclk, lrck, sdata, req, ovr, und} for model state c.
   function automatic logic [5:0] exp_out(input mdl_t c);
      int unsigned k, b, p;
      logic bc, lr, sd;
      logic [15:0] w;
      bc = ((c.t / BclkDiv) % 2) == 1;
      k  = c.t / (2 * BclkDiv);
      lr = 1'b0;
      sd = 1'b0;
      if (k > 0) begin
         b  = (k - 1) % (2 * SlotBits);
         lr = (b >= SlotBits);
         p  = b % SlotBits;
         w  = lr ? c.wr : c.wl;
         if (p >= 1 && p <= DataW) sd = w[4'(DataW - p)];
      end
      return {bc, lr, sd, c.req, c.ovr, c.und};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= '0;
      else     m <= step(m, valid, l_in, r_in, mute, clr);
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string nm, input int unsigned act, input int unsigned exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Every cycle outside reset, all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) check("outputs", 32'({bclk, lrck, sdata, req, ovr, und}), 32'(exp_out(m)));
      end
   end

   task automatic wait_req();
      int c;
      c = 0;
      while (!req && c < FrameClk + 20) begin
         @(negedge clk);
         c++;
      end
      if (!req) check("req_timeout", 0, 1);
   endtask

   task automatic pulse_valid(input logic [15:0] l, input logic [15:0] r);
      l_in  = l;
      r_in  = r;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Called on the negedge where req is high (bit 0 of the frame).
   task automatic capture(output logic [15:0] wl, output logic [15:0] wr, output logic pad);
      logic b;
      wl  = '0;
      wr  = '0;
      pad = sdata;
      for (int i = 1; i < 64; i++) begin
         repeat (2 * BclkDiv) @(negedge clk);
         b = sdata;
         if (i >= 1 && i <= 16)       wl[16-i] = b;
         else if (i >= 33 && i <= 48) wr[48-i] = b;
         else                         pad = pad | b;
      end
   endtask

   // Release reset and count clocks to the first load; optionally write a pair at clock 3.
   task automatic release_and_time(input logic wr, input logic [15:0] l, input logic [15:0] r,
                                   output int cyc);
      @(negedge clk);
      rst = 1'b0;
      cyc = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         l_in  = l;
         r_in  = r;
         valid = wr && (c == 3);
         if (req) begin
            cyc = c;
            break;
         end
      end
      valid = 1'b0;
   endtask

   // ---------------- table-driven frame vectors ----------------
   typedef struct {
      logic [15:0] l, r;
      logic        mu;
      logic [15:0] exp_l, exp_r;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] cl, cr;
      logic        pad;
      int          cyc;

      tbl[0] = '{16'h8001, 16'h7FFE, 1'b0, 16'h8001, 16'h7FFE};
      tbl[1] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hA5A5, 16'h5A5A};
      tbl[2] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000};
      tbl[3] = '{16'hBEEF, 16'hCAFE, 1'b1, 16'h0000, 16'h0000};
      tbl[4] = '{16'h0001, 16'h8000, 1'b0, 16'h0001, 16'h8000};

      // Reset state, then first load with no samples.
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({bclk, lrck, sdata, req, ovr, und}), 0);
      release_and_time(1'b0, 16'h0, 16'h0, cyc);
      check("first_load_cycle", cyc, 8);
      check("first_underrun", 32'(und), 1);
      capture(cl, cr, pad);
      check("empty_frame_l", cl, 0);
      check("empty_frame_r", cr, 0);
      check("empty_frame_pad", 32'(pad), 0);

      // Table vectors: write one pair per frame, capture the next frame.
      foreach (tbl[i]) begin
         wait_req();
         repeat (20) @(negedge clk);
         mute = tbl[i].mu;
         pulse_valid(tbl[i].l, tbl[i].r);
         wait_req();
         mute = 1'b0;
         capture(cl, cr, pad);
         check($sformatf("tbl%0d_l", i), cl, tbl[i].exp_l);
         check($sformatf("tbl%0d_r", i), cr, tbl[i].exp_r);
         check($sformatf("tbl%0d_pad", i), 32'(pad), 0);
      end

      // Overrun: two writes 10 cycles apart in one frame, latest wins.
      wait_req();
      pulse_clr();
      repeat (20) @(negedge clk);
      pulse_valid(16'h1111, 16'h2222);
      repeat (9) @(negedge clk);
      pulse_valid(16'h3333, 16'h4444);
      check("overrun_set", 32'(ovr), 1);
      wait_req();
      capture(cl, cr, pad);
      check("overrun_frame_l", cl, 16'h3333);
      check("overrun_frame_r", cr, 16'h4444);

      // Write exactly in the load cycle: frame takes A, next frame takes C, no overrun.
      wait_req();
      pulse_clr();
      pulse_valid(16'hAAAA, 16'h0A0A);
      repeat (FrameClk - 3) @(negedge clk);
      l_in  = 16'hCCCC;
      r_in  = 16'h0C0C;
      valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      check("load_cycle_req", 32'(req), 1);
      check("load_cycle_no_ovr", 32'(ovr), 0);
      capture(cl, cr, pad);
      check("load_cycle_frame_l", cl, 16'hAAAA);
      check("load_cycle_frame_r", cr, 16'h0A0A);
      wait_req();
      capture(cl, cr, pad);
      check("after_load_frame_l", cl, 16'hCCCC);
      check("after_load_frame_r", cr, 16'h0C0C);
      check("after_load_no_ovr", 32'(ovr), 0);

      // Mute at load, then an empty-buffer frame replays the muted pair.
      wait_req();
      repeat (10) @(negedge clk);
      pulse_valid(16'h1234, 16'h5678);
      mute = 1'b1;
      wait_req();
      mute = 1'b0;
      capture(cl, cr, pad);
      check("mute_frame_l", cl, 0);
      check("mute_frame_r", cr, 0);
      pulse_clr();
      wait_req();
      check("replay_underrun", 32'(und), 1);
      capture(cl, cr, pad);
      check("replay_frame_l", cl, 16'h1234);
      check("replay_frame_r", cr, 16'h5678);

      // Reset in the middle of the right slot.
      wait_req();
      repeat (300) @(negedge clk);
      check("mid_right_lrck", 32'(lrck), 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check("async_reset_outputs", 32'({bclk, lrck, sdata, req, ovr, und}), 0);
      repeat (3) @(negedge clk);
      release_and_time(1'b1, 16'h8001, 16'h7FFE, cyc);
      check("reload_cycle", cyc, 8);
      check("reload_no_underrun", 32'(und), 0);
      capture(cl, cr, pad);
      check("reload_frame_l", cl, 16'h8001);
      check("reload_frame_r", cr, 16'h7FFE);
      check("reload_frame_pad", 32'(pad), 0);

      // Randomized stretch; the per-cycle model check does the work.
      for (int c = 0; c < 8000; c++) begin
         @(negedge clk);
         valid = ($urandom_range(0, 299) == 0);
         l_in  = 16'($urandom);
         r_in  = 16'($urandom);
         clr   = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 999) == 0) mute = ~mute;
      end
      @(negedge clk);
      valid = 1'b0;
      clr   = 1'b0;
      mute  = 1'b0;
      repeat (20) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
